// File: rtl/datamem_arbiter.sv
// Round-robin arbiter between the CPU data port (0) and the loader (1) for the
// shared edge-triggered data memory; emits clean MEM_LAT-wide strobes and a one-cycle ack.
module datamem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              grant;
    req_t              sel;

    always_comb begin
        // On a tie the requester that was not served last wins.
        grant = (req0 && req1) ? ~owner_q : req1;
        sel   = grant ? '{we: we1, addr: addr1, wdata: wdata1}
                      : '{we: we0, addr: addr0, wdata: wdata0};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        we_d     = we_q;
        busy_d   = busy_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = grant;
                    we_d    = sel.we;
                    addr_d  = sel.addr;
                    wdata_d = sel.wdata;
                    rd_d    = ~sel.we;
                    wr_d    = sel.we;
                    busy_d  = 1'b1;
                    cnt_d   = 4'd1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == LAT) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = RECOVER;
                    if (!we_q) begin
                        if (owner_q) rdata1_d = mem_readdata;
                        else         rdata0_d = mem_readdata;
                    end
                    if (owner_q) ack1_d = 1'b1;
                    else         ack0_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RECOVER: begin
                // Strobes are already low here, so the next access gets a fresh rising edge.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            owner_q  <= 1'b1;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign ack0          = ack0_q;
    assign ack1          = ack1_q;
    assign rdata0        = rdata0_q;
    assign rdata1        = rdata1_q;
    assign mem_address   = addr_q;
    assign mem_writeData = wdata_q;
    assign mem_memRead   = rd_q;
    assign mem_memWrite  = wr_q;
    assign busy          = busy_q;
    assign owner         = owner_q;

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
Two-requester arbiter and access sequencer for the shared word-addressed data memory (1024 x 32, edge-triggered on rising memRead/memWrite). It grants one requester at a time with round-robin priority and latches that requester's address and data. It produces clean strobe pulses (low -> high for MEM_LAT cycles -> low), captures read data and returns a one-cycle ack. It sits between the CPU data port (requester 0) and the program/DMA loader (requester 1) on one side and the data memory on the other.

Parameters:
ADDR_W, 32, width of requester and memory address (word index; only 0..1023 valid, passed verbatim, not range-checked)
DATA_W, 32, data width
MEM_LAT, 2, cycles a strobe is held high; legal range 1..15

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req0  in  1  requester 0 access request; held until ack0
we0  in  1  requester 0: 1 = write, 0 = read; sampled with req0
addr0  in  ADDR_W  requester 0 word address
wdata0  in  DATA_W  requester 0 write data
ack0  out  1  one-cycle completion pulse to requester 0
rdata0  out  DATA_W  requester 0 read data, valid from ack0, held
req1, we1, addr1, wdata1, ack1, rdata1  same as above for requester 1
mem_address  out  ADDR_W  latched address to memory
mem_writeData  out  DATA_W  latched write data to memory
mem_memRead  out  1  read strobe
mem_memWrite  out  1  write strobe
mem_readdata  in  DATA_W  memory read data
busy  out  1  high in ACCESS and RECOVER
owner  out  1  requester currently or last granted

Behaviour:
- All outputs are registered. Reset values: ack0/1=0, rdata0/1=0, mem_address=0, mem_writeData=0, both strobes=0, busy=0, owner=1, state=IDLE, strobe counter=0. Because owner resets to 1, requester 0 wins the first tie.
- Grant is decided in IDLE from req0/req1 and owner:
  - If only one request is active, that requester wins.
  - If both are active, the requester other than owner wins.
  - If none is active, stay in IDLE.
- On grant at the end of IDLE cycle C:
  - Load mem_address and mem_writeData (writeData is loaded for reads too; harmless).
  - Set owner to the winner, latch the we bit, raise exactly one strobe (memWrite if we=1, else memRead), set busy=1, go to ACCESS.
- ACCESS lasts cycles C+1..C+MEM_LAT.
  - The strobe stays high and the address/data stay stable throughout.
  - The counter runs 1..MEM_LAT. At the end of the last ACCESS cycle, drop the strobe.
  - On a read, register mem_readdata into the owner's rdata register at that same edge.
  - Then go to RECOVER.
- RECOVER is cycle C+MEM_LAT+1.
  - Both strobes are low and ack of the owner is 1 for exactly this cycle.
  - The owner's rdata is valid (reads) or unchanged (writes). The non-owner's rdata never changes.
  - Next state is IDLE; busy drops.
  - This guarantees at least one low cycle between strobes, so every access presents a fresh rising edge.
- Latency: ack is seen MEM_LAT+1 cycles after the IDLE cycle in which req was sampled. Minimum issue spacing is MEM_LAT+2 cycles.
- Requester contract:
  - Hold req/we/addr/wdata stable until ack. These inputs are sampled only in IDLE; changes during ACCESS/RECOVER are ignored.
  - Deassert req on the edge ending the ack cycle. A req still high in the following IDLE cycle is a new transaction.
- A request from the non-owner arriving during ACCESS/RECOVER waits; it wins in the next IDLE.
- memRead and memWrite are never high together.
- Reset mid-operation: at the reset edge, strobes drop, no ack is issued and the transaction is abandoned. Memory may already be modified by a completed rising edge.

Test Plan:
- Single read: preload mem[5]=0xDEADBEEF in the memory model; req0, we0=0, addr0=5 in cycle 0 -> memRead high cycles 1-2, ack0 cycle 3, rdata0=0xDEADBEEF, rdata1 stays 0.
- Write then read: req1 write addr 10 data 0x12345678, then req1 read addr 10 -> acks at cycles 3 and 7, rdata1=0x12345678, memWrite asserted only in the write.
- Simultaneous contention: req0 and req1 held high continuously with requesters re-requesting after each ack -> grants alternate 0,1,0,1 (first grant goes to 0 after reset), owner toggles, no strobe overlap.
- Back-to-back single requester: four consecutive req0 reads -> one transaction per 4 cycles (MEM_LAT=2), each strobe preceded by a low cycle.
- Reset mid-access: assert rst in cycle 2 of a read -> cycle 3 strobes=0, ack0 never pulses, rdata0=0, state IDLE, next req0 is served normally.
- Parameter sweep: MEM_LAT=1 and MEM_LAT=4 -> ack at cycle MEM_LAT+1, strobe width exactly MEM_LAT cycles.
